// File: rtl/fc_feeder_if.sv
// rtl/fc_feeder_if.sv - activation feed and MAC lane bundle for fc_feeder
//
// Purpose: groups the upstream activation handshake and the three-lane MAC
// beat outputs into one bundle.
//   slave  : the feeder (accepts activations, drives MAC beats)
//   master : the surrounding logic (drives activations and mac_done)
// Signals:
//   feat_valid / feat_data / feat_ready : serial activation handshake
//   mac_in_1..3                         : lane activations for the beat
//   mac_valid / mac_first / mac_last    : beat qualifiers
//   mac_done                            : MAC finished the held frame
//   busy                                : frame streaming or awaiting mac_done
interface fc_feeder_if #(
  parameter int DW = 2
);
  logic          feat_valid;
  logic [DW-1:0] feat_data;
  logic          feat_ready;
  logic [DW-1:0] mac_in_1;
  logic [DW-1:0] mac_in_2;
  logic [DW-1:0] mac_in_3;
  logic          mac_valid;
  logic          mac_first;
  logic          mac_last;
  logic          mac_done;
  logic          busy;

  modport slave (
    input  feat_valid, feat_data, mac_done,
    output feat_ready, mac_in_1, mac_in_2, mac_in_3,
           mac_valid, mac_first, mac_last, busy
  );

  modport master (
    output feat_valid, feat_data, mac_done,
    input  feat_ready, mac_in_1, mac_in_2, mac_in_3,
           mac_valid, mac_first, mac_last, busy
  );
endinterface

// File: rtl/fc_feeder.sv
// rtl/fc_feeder.sv - ping-pong activation stager feeding the three-lane MAC
//
// Purpose: collects serial 2-bit activations into one of two frame banks and
// replays each full frame as DEPTH beats of N_LANE activations, then holds
// the bank until the MAC signals mac_done. One bank fills while the other
// streams.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fc_feeder_if.slave (activation handshake in, MAC beats out)
module fc_feeder #(
  parameter int N_LANE = 3,
  parameter int DEPTH  = 36,
  parameter int DW     = 2
) (
  input  logic           clk,
  input  logic           rst,
  fc_feeder_if.slave     bus
);

  localparam int FRAME = N_LANE * DEPTH;
  localparam int IW    = $clog2(FRAME);
  localparam int BW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  logic [DW-1:0] mem [2][FRAME];

  state_t        state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic          rd_bank, rd_bank_n;
  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic [1:0]    full, full_n;

  logic          wr_fire;
  logic          wr_last;
  logic          bank_release;

  // Registered-output staging values
  logic          valid_d, first_d, last_d, busy_d;
  logic [DW-1:0] in1_d, in2_d, in3_d;
  logic [IW-1:0] idx1, idx2, idx3;

  assign bus.feat_ready = !rst && !full[wr_bank];
  assign wr_fire        = bus.feat_valid && bus.feat_ready;
  assign wr_last        = wr_fire && (wr_idx == IW'(FRAME - 1));
  assign bank_release   = (state == WAIT_DONE) && bus.mac_done;

  // Write side: the write bank is never the held read bank, so setting and
  // clearing in the same cycle touch different flags.
  always_comb begin
    full_n = full;
    if (bank_release) full_n[rd_bank] = 1'b0;
    if (wr_last)      full_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      full <= full_n;
      if (wr_fire) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  // Buffer contents need no reset; full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_idx] <= bus.feat_data;
  end

  // Read FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      rd_bank <= rd_bank_n;
    end
  end

  // Read FSM: next state
  always_comb begin
    state_n   = state;
    beat_n    = beat;
    rd_bank_n = rd_bank;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_n = STREAM;
          beat_n  = '0;
        end
      end
      STREAM: begin
        if (beat == BW'(DEPTH - 1)) state_n = WAIT_DONE;
        else                         beat_n  = beat + 1'b1;
      end
      WAIT_DONE: begin
        if (bus.mac_done) begin
          state_n   = IDLE;
          rd_bank_n = ~rd_bank;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Read FSM: outputs. Computed from the next state/beat so the registered
  // outputs line up with the state they describe.
  always_comb begin
    idx1    = IW'(beat_n);
    idx2    = IW'(beat_n) + IW'(DEPTH);
    idx3    = IW'(beat_n) + IW'(2 * DEPTH);
    valid_d = (state_n == STREAM);
    first_d = valid_d && (beat_n == '0);
    last_d  = valid_d && (beat_n == BW'(DEPTH - 1));
    busy_d  = (state_n != IDLE);
    in1_d   = '0;
    in2_d   = '0;
    in3_d   = '0;
    if (valid_d) begin
      in1_d = mem[rd_bank][idx1];
      in2_d = mem[rd_bank][idx2];
      in3_d = mem[rd_bank][idx3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mac_valid <= 1'b0;
      bus.mac_first <= 1'b0;
      bus.mac_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mac_in_1  <= '0;
      bus.mac_in_2  <= '0;
      bus.mac_in_3  <= '0;
    end else begin
      bus.mac_valid <= valid_d;
      bus.mac_first <= first_d;
      bus.mac_last  <= last_d;
      bus.busy      <= busy_d;
      bus.mac_in_1  <= in1_d;
      bus.mac_in_2  <= in2_d;
      bus.mac_in_3  <= in3_d;
    end
  end

endmodule
